instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Initiator side of the instruction-memory read interface. Owns the fetch PC and drives the word address to the
//  combinational instruction ROM. Captures the returned word plus its PC into a small prefetch FIFO.
//  Presents instructions to decode over a valid/ready handshake. Branch redirect flushes the FIFO and reloads the PC.
//  Sits between the instruction ROM and the decode/control stage of the ARM core.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch PC after reset; bits [1:0] must be 0
//  FIFO_DEPTH  4              prefetch entries, power of two, 2..16
// PORTS
//  clk          in   1   rising-edge clock, single clock domain
//  reset        in   1   synchronous, active-high reset
//  imem_addr    out  32  word address to instruction ROM, = fetch_pc, bits [1:0] always 0
//  imem_rd      in   32  ROM read data, valid in the same cycle as imem_addr (combinational ROM)
//  if_valid     out  1   FIFO head holds an instruction
//  if_ready     in   1   decode accepts head this cycle
//  if_instr     out  32  head instruction word
//  if_pc        out  32  address of head instruction
//  if_pc8       out  32  if_pc + 8 (ARM R15 read value), mod 2^32
//  br_taken     in   1   redirect request from execute
//  br_target    in   32  redirect address; bits [1:0] ignored (forced 0)
//  halted       out  1   self-loop halt reached (0 when IFU_SELF_LOOP_HALT_EN is undefined)
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, FIFO empty, if_valid=0, if_instr/if_pc=0, if_pc8=8, halted=0. Reset overrides all.
//  - Enqueue cond: !br_taken && !halted && (count<FIFO_DEPTH || (if_valid&&if_ready)).
//  - On enqueue: write {fetch_pc, imem_rd}; fetch_pc <= fetch_pc+4. Wraps 32'hFFFF_FFFC -> 0.
//  - Dequeue: if_valid && if_ready pops the head. A full FIFO with a same-cycle dequeue also enqueues; count unchanged.
//  - Redirect (br_taken=1) has top priority. FIFO flushed, including any head being dequeued this cycle: that head
//    is still consumed by decode, no new head appears next cycle. fetch_pc <= {br_target[31:2],2'b00}.
//    No enqueue this cycle. halted cleared.
//  - Latency: instruction at new PC visible on if_valid 1 cycle after redirect/reset release; steady-state 1 instr/cycle.
//  - Empty: if_valid=0; if_instr/if_pc hold the last head value (don't-care to decode).
//  - Full && !if_ready: fetch_pc holds, imem_addr stable, no enqueue.
//  - count width clog2(FIFO_DEPTH)+1; read/write pointers wrap modulo FIFO_DEPTH.
// CONFIGURATION
//  IFU_SELF_LOOP_HALT_EN defined:
//    - An enqueue of 32'hEAFF_FFFE (BAL to self) sets halted=1 the next cycle.
//    - Fetch stops with fetch_pc left at that instruction's address. The entry is still delivered to decode.
//    - Only br_taken or reset resume fetch.
//  IFU_SELF_LOOP_HALT_EN undefined: no detection, halted tied 0, fetch continues (self-loop refetched via br_taken).
// STRUCTURE
//  - Shared package ifu_pkg: IFU_BAL_SELF=32'hEAFF_FFFE, IFU_PC_STEP=4, IFU_PC8_OFS=8.
//  - Shared package ifu_pkg also holds the entry typedef {pc[31:0], instr[31:0]}.
//  - Sub-module ifu_fifo: sync FIFO with flush, simultaneous push/pop, count output. Parameter DEPTH, width 64.
//  - Top: PC register, enqueue/redirect priority logic, halt detect.
// TESTING
//  - Reset, ROM holding the standard test program, if_ready=1: if_valid 1 cycle after reset low.
//    Sequence if_pc=0,4,8,.. with if_instr E2022000,E3823000,E3834005; if_pc8=8 at pc 0.
//  - if_ready=0 for 10 cycles, DEPTH 4: count saturates at 4, imem_addr holds 0x10, no entry lost.
//    Then if_ready=1: entries 0x0..0xC drain in order.
//  - br_taken with br_target=32'h0000_0017 while FIFO holds 3 entries: next cycle if_valid=0, FIFO empty.
//    Following cycle if_pc=0x14, if_instr=E2499001.
//  - Full FIFO, if_ready=1 each cycle: one push + one pop per cycle, count stays 4, PCs contiguous.
//  - RESET_PC=32'hFFFF_FFF8: fetch 0xFFFFFFF8, 0xFFFFFFFC, then 0x0. if_pc8 at 0xFFFFFFFC = 0x4.
//  - IFU_SELF_LOOP_HALT_EN: fetch reaches 0x34 (EAFFFFFE): halted=1, imem_addr stays 0x34, entry delivered once.
//    br_taken to 0 clears halted. Macro undefined: halted=0, fetch continues to 0x38.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared constants and the prefetch entry type for the instruction fetch unit.
package ifu_pkg;

  localparam logic [31:0] IFU_BAL_SELF = 32'hEAFF_FFFE;
  localparam logic [31:0] IFU_PC_STEP  = 32'd4;
  localparam logic [31:0] IFU_PC8_OFS  = 32'd8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifu_entry_t;

  // Word-align an address by forcing bits [1:0] to zero.
  function automatic logic [31:0] ifu_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO: flush, simultaneous push/pop, occupancy count.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  ifu_entry_t               wdata_i,
  output ifu_entry_t               rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  ifu_entry_t            mem_q [DEPTH];
  ifu_entry_t            mem_d [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  full, empty;
  logic                  push_ok, pop_ok;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = push_i && !flush_i && (!full || pop_i);
  assign pop_ok  = pop_i && !flush_i && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, prefetch FIFO, branch redirect.
// Optional self-loop halt detection enabled by defining IFU_SELF_LOOP_HALT_EN.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc8,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        halted
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            halted_q, halted_d;
  ifu_entry_t      hold_q, hold_d;
  ifu_entry_t      head;
  ifu_entry_t      wr_entry;
  logic [CntW-1:0] count;
  logic            fifo_full;
  logic            deq, enq;
  logic            halt_hit;

  assign fifo_full = (count == CntW'(FIFO_DEPTH));
  assign if_valid  = (count != '0);
  assign deq       = if_valid && if_ready;
  assign enq       = !br_taken && !halted_q && (!fifo_full || deq);

  assign wr_entry.pc    = fetch_pc_q;
  assign wr_entry.instr = imem_rd;

`ifdef IFU_SELF_LOOP_HALT_EN
  assign halt_hit = enq && (imem_rd == IFU_BAL_SELF);
`else
  assign halt_hit = 1'b0;
`endif

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    halted_d   = halted_q;
    if (br_taken) begin
      fetch_pc_d = ifu_align(br_target);
      halted_d   = 1'b0;
    end else if (halt_hit) begin
      // Park on the self-loop so imem_addr keeps pointing at it.
      halted_d   = 1'b1;
    end else if (enq) begin
      fetch_pc_d = fetch_pc_q + IFU_PC_STEP;
    end
  end

  // Outputs keep the last delivered head while the FIFO is empty.
  always_comb begin
    hold_d = hold_q;
    if (if_valid) begin
      hold_d = head;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      halted_q   <= 1'b0;
      hold_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      halted_q   <= halted_d;
      hold_q     <= hold_d;
    end
  end

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (br_taken),
    .push_i  (enq),
    .pop_i   (deq),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .count_o (count)
  );

  assign imem_addr = fetch_pc_q;
  assign if_instr  = if_valid ? head.instr : hold_q.instr;
  assign if_pc     = if_valid ? head.pc : hold_q.pc;
  assign if_pc8    = if_pc + IFU_PC8_OFS;
  assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit; honours IFU_SELF_LOOP_HALT_EN when defined.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr, imem_rd;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc, if_pc8;
  logic        br_taken;
  logic [31:0] br_target;
  logic        halted;

  logic [31:0] imem_addr2, imem_rd2;
  logic        if_valid2;
  logic [31:0] if_instr2, if_pc2, if_pc8_2;
  logic        halted2;

  int          n_checks;
  int          n_errors;
  exp_t        exp_q[$];
  logic [31:0] m_pc;
  logic        m_halt;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h00:  return 32'hE202_2000;
      32'h04:  return 32'hE382_3000;
      32'h08:  return 32'hE383_4005;
      32'h14:  return 32'hE249_9001;
      32'h34:  return 32'hEAFF_FFFE;
      default: return {16'hE1A0, a[15:0]};
    endcase
  endfunction

  assign imem_rd  = rom(imem_addr);
  assign imem_rd2 = rom(imem_addr2);

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .imem_rd   (imem_rd),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .if_pc8    (if_pc8),
    .br_taken  (br_taken),
    .br_target (br_target),
    .halted    (halted)
  );

  instr_fetch_unit #(
    .RESET_PC   (32'hFFFF_FFF8),
    .FIFO_DEPTH (DEPTH)
  ) dut_wrap (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr2),
    .imem_rd   (imem_rd2),
    .if_valid  (if_valid2),
    .if_ready  (1'b1),
    .if_instr  (if_instr2),
    .if_pc     (if_pc2),
    .if_pc8    (if_pc8_2),
    .br_taken  (1'b0),
    .br_target (32'h0),
    .halted    (halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    if_ready  = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", {31'b0, if_valid}, 32'd0);
    check_eq("rst_instr", if_instr, 32'h0);
    check_eq("rst_pc", if_pc, 32'h0);
    check_eq("rst_pc8", if_pc8, 32'h8);
    check_eq("rst_halted", {31'b0, halted}, 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    reset = 1'b0;
    exp_q.delete();
    m_pc   = 32'h0;
    m_halt = 1'b0;
  endtask

  // One clock: drive inputs, check outputs against the scoreboard, advance the model.
  task automatic cycle(input logic rdy, input logic br, input logic [31:0] tgt);
    exp_t e;
    logic [31:0] word;
    if_ready  = rdy;
    br_taken  = br;
    br_target = tgt;
    #1;
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("if_valid", {31'b0, if_valid}, {31'b0, exp_q.size() != 0});
    check_eq("halted", {31'b0, halted}, {31'b0, m_halt});
    if (exp_q.size() != 0 && rdy) begin
      e = exp_q.pop_front();
      check_eq("if_pc", if_pc, e.pc);
      check_eq("if_instr", if_instr, e.instr);
      check_eq("if_pc8", if_pc8, e.pc + 32'd8);
    end
    if (br) begin
      exp_q.delete();
      m_pc   = tgt & ~32'h3;
      m_halt = 1'b0;
    end else if (!m_halt && exp_q.size() < DEPTH) begin
      word = rom(m_pc);
      exp_q.push_back('{pc: m_pc, instr: word});
`ifdef IFU_SELF_LOOP_HALT_EN
      if (word == 32'hEAFF_FFFE) m_halt = 1'b1;
      else m_pc = m_pc + 32'd4;
`else
      m_pc = m_pc + 32'd4;
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset     = 1'b1;
    if_ready  = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    @(negedge clk);

    // Streaming from reset; the second instance checks PC wrap from 0xFFFFFFF8.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: check_eq("wrap_valid0", {31'b0, if_valid2}, 32'd0);
        1: check_eq("wrap_pc_f8", if_pc2, 32'hFFFF_FFF8);
        2: begin
          check_eq("wrap_pc_fc", if_pc2, 32'hFFFF_FFFC);
          check_eq("wrap_pc8_fc", if_pc8_2, 32'h0000_0004);
        end
        3: check_eq("wrap_pc_0", if_pc2, 32'h0);
        default: ;
      endcase
      cycle(1'b1, 1'b0, 32'h0);
    end
    // Redirect while the head is being consumed.
    cycle(1'b1, 1'b1, 32'h0000_0008);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // Backpressure fill, then drain and steady full-rate streaming.
    do_reset();
    repeat (10) cycle(1'b0, 1'b0, 32'h0);
    check_eq("stall_addr", imem_addr, 32'h10);
    repeat (10) cycle(1'b1, 1'b0, 32'h0);

    // Redirect with 3 entries queued, then run into the self-loop at 0x34.
    do_reset();
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_0017);
    cycle(1'b0, 1'b0, 32'h0);
    repeat (20) cycle(1'b1, 1'b0, 32'h0);
`ifdef IFU_SELF_LOOP_HALT_EN
    check_eq("halt_addr", imem_addr, 32'h34);
`else
    check_eq("no_halt_flag", {31'b0, halted}, 32'd0);
`endif
    cycle(1'b1, 1'b1, 32'h0);
    repeat (5) cycle(1'b1, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
